udp_rx: RTL and testbench
=========================

Name: udp_rx

Overview:
Receive-side counterpart of the UDP transmit path. It consumes the N-bit stream carrying an IP payload from the IP receive layer and accepts it only when protocol_in is 17. It parses the 8-byte UDP header, forwards exactly (length − 8) payload bytes downstream with an end marker, and verifies the UDP checksum against the IPv4 pseudo-header. It sits between the IP receive layer and the application payload sink.

Parameters:
N, 2, stream chunk width in bits; legal values 1, 2, 4, 8 (must divide 8)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
axiiv  input  1  input chunk valid; high contiguously for one IP payload, low ≥1 cycle between payloads
axiid  input  N  input chunk
protocol_in  input  8  IP protocol of current packet, stable while axiiv high
src_ip_in  input  32  IP source address, stable while axiiv high
dst_ip_in  input  32  IP destination address, stable while axiiv high
axiov  output  1  payload chunk valid
axiod  output  N  payload chunk
axi_last  output  1  marks the final payload chunk (with axiov)
src_port_out  output  16  parsed source port
dst_port_out  output  16  parsed destination port
length_out  output  16  parsed UDP length field
header_valid  output  1  one-cycle pulse when all header fields are valid
done  output  1  one-cycle pulse at segment end
checksum_ok  output  1  checksum result, valid from done
length_err  output  1  length field < 8 or segment truncated, valid from done

Behaviour:
- Reset: synchronous, active-high. All outputs and registers are 0. State goes to WAIT_GAP, so a frame already in progress is never parsed from its middle.
- Wire order: bytes arrive most-significant first (network order). Within a byte, the least-significant N bits arrive first, the same order the transmit side uses. A byte completes after 8/N accepted chunks.
- States:
  - WAIT_GAP: stays until axiiv=0, then goes to IDLE.
  - IDLE: on axiiv=1 with protocol_in==17, the chunk is accepted as header byte 0 chunk 0 and state goes to HEADER. On axiiv=1 with any other protocol, state goes to WAIT_GAP with no outputs.
  - HEADER: assembles bytes 0–7 into src port, dst port, length, checksum.
    - The cycle after the last header chunk is accepted, the field outputs update and header_valid pulses.
    - Next state: PAYLOAD if length > 8; FINISH if length == 8; FINISH with length_err=1 if length < 8.
  - PAYLOAD: each accepted chunk is echoed on axiod with axiov=1 exactly one cycle later (registered, latency 1).
    - A 16-bit byte counter tracks payload bytes.
    - axi_last=1 on the output cycle of the final chunk of byte (length − 9). State then goes to DRAIN.
  - DRAIN: remaining input (Ethernet padding etc.) is dropped with axiov=0. Goes to FINISH once the final payload chunk has been accepted; WAIT_GAP applies afterwards.
  - FINISH: folds the checksum, pulses done, then goes to WAIT_GAP (or IDLE if axiiv is already 0).
- Truncation: axiiv falls in HEADER or PAYLOAD before length bytes are received.
  - Goes to FINISH with length_err=1 and checksum_ok=0.
  - No axi_last is emitted.
  - If this happens in HEADER, header_valid does not pulse.
- Checksum:
  - 32-bit accumulator initialised at the start of a frame.
  - Adds the pseudo-header: src_ip[31:16], src_ip[15:0], dst_ip[31:16], dst_ip[15:0], 16'h0011, and the UDP length. The length is added once header byte 5 completes.
  - Then adds every 16-bit word of the header and payload, taken from the first `length` bytes only (padding is excluded). An odd final byte is padded with a low byte of 0x00.
  - At FINISH the accumulator is folded (carries added back twice), giving a 16-bit sum S.
  - checksum_ok = (S == 16'hFFFF) OR (received checksum field == 0).
- done timing: done pulses exactly 2 cycles after the last payload chunk is accepted, or after the header chunk when length ≤ 8, or after the cycle axiiv fell on truncation.
- Result hold: checksum_ok and length_err hold their values until the next frame's first accepted chunk clears them. Port and length outputs hold until the next header_valid.
- protocol_in, src_ip_in and dst_ip_in are sampled only while the block is in IDLE or HEADER.

Decomposition:
- Shared package holds UDP_PROTO=8'd17, UDP_HDR_BYTES=8, the state enum type, and a ones-complement fold function.
- One sub-module, udp_csum_acc, does the word assembly and accumulation: byte in, byte_valid, clear, fold → 16-bit sum.

Test Plan:
- N=2, protocol 17, src 10.0.0.1, dst 10.0.0.2, ports 0x1234→0x5678, length 12, payload DE AD BE EF, correct checksum:
  - header_valid with src_port_out=0x1234, dst_port_out=0x5678, length_out=12.
  - 16 axiov chunks reproduce the payload; axi_last on the 16th.
  - done with checksum_ok=1, length_err=0.
- Same frame with one payload bit flipped → payload forwarded, checksum_ok=0. Same frame with checksum field 0 → checksum_ok=1.
- Length 9, payload 0xA5, followed by 10 padding bytes:
  - 4 output chunks, then axi_last.
  - Padding produces no axiov and does not affect the checksum (odd-byte pad rule).
- protocol_in=6 → no header_valid, no axiov, no done. A following UDP frame after a gap is parsed correctly.
- axiiv drops after 2 payload bytes of a length-20 segment → 8 chunks out, no axi_last, done with length_err=1, checksum_ok=0. Separately, length field 4 → length_err=1, no axiov.
- rst asserted mid-payload → all outputs 0 next cycle. Rest of that frame ignored (WAIT_GAP). Next frame after a gap is received correctly.

Source files
------------

// File: rtl/udp_rx_pkg.sv
// udp_rx_pkg: shared UDP constants, receive state type and ones-complement fold
package udp_rx_pkg;
  localparam logic [7:0] UDP_PROTO = 8'd17;
  localparam int UDP_HDR_BYTES = 8;
  typedef enum logic [2:0] {WAIT_GAP, IDLE, HEADER, PAYLOAD, DRAIN, FINISH} state_t;
  function automatic logic [15:0] csum_fold(input logic [31:0] a);
    logic [16:0] s;
    s = {1'b0, a[15:0]} + {1'b0, a[31:16]};
    s = {1'b0, s[15:0]} + {16'd0, s[16]};
    return s[15:0];
  endfunction
endpackage

// File: rtl/udp_csum_acc.sv
// udp_csum_acc: pairs bytes into 16-bit words, accumulates them plus injected words, folds to a 16-bit sum
module udp_csum_acc
  import udp_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [31:0] init,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic [15:0] word_in,
  input  logic        word_valid,
  output logic [15:0] sum
);
  logic [31:0] acc, acc_base;
  logic [7:0] hi;
  logic odd, odd_base;
  always_comb begin
    acc_base = clear ? init : acc;
    odd_base = clear ? 1'b0 : odd;
    sum = csum_fold(acc + (odd ? {16'd0, hi, 8'd0} : 32'd0));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      hi <= '0;
      odd <= 1'b0;
    end else begin
      acc <= acc_base + ((byte_valid && odd_base) ? {16'd0, hi, byte_in} : 32'd0) + (word_valid ? {16'd0, word_in} : 32'd0);
      odd <= byte_valid ? !odd_base : odd_base;
      if (byte_valid && !odd_base) hi <= byte_in;
    end
  end
endmodule

// File: rtl/udp_rx.sv
// udp_rx: parses UDP header from an N-bit IP payload stream, forwards the payload and verifies the checksum
module udp_rx
  import udp_rx_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         axiiv,
  input  logic [N-1:0] axiid,
  input  logic [7:0]   protocol_in,
  input  logic [31:0]  src_ip_in,
  input  logic [31:0]  dst_ip_in,
  output logic         axiov,
  output logic [N-1:0] axiod,
  output logic         axi_last,
  output logic [15:0]  src_port_out,
  output logic [15:0]  dst_port_out,
  output logic [15:0]  length_out,
  output logic         header_valid,
  output logic         done,
  output logic         checksum_ok,
  output logic         length_err
);
  localparam int CPB = 8 / N;
  state_t state, state_n;
  logic [2:0] cc;
  logic [7:0] sr, cur_byte;
  logic [55:0] hdr_sr;
  logic [15:0] bcnt, csum_field, hdr_len, sum;
  logic [31:0] pseudo;
  logic udp_start, acc_en, byte_done, hdr_last, pay_last, err;
  always_comb begin
    udp_start = state == IDLE && axiiv && protocol_in == UDP_PROTO;
    acc_en = axiiv && (udp_start || state == HEADER || state == PAYLOAD);
    byte_done = acc_en && cc == 3'(CPB - 1);
    cur_byte = 8'({axiid, sr} >> N);
    hdr_len = hdr_sr[23:8];
    hdr_last = state == HEADER && byte_done && bcnt == 16'(UDP_HDR_BYTES - 1);
    pay_last = state == PAYLOAD && byte_done && bcnt == length_out - 16'd1;
    pseudo = 32'(src_ip_in[31:16]) + 32'(src_ip_in[15:0]) + 32'(dst_ip_in[31:16]) + 32'(dst_ip_in[15:0]) + 32'(UDP_PROTO);
    state_n = state;
    case (state)
      WAIT_GAP: state_n = axiiv ? WAIT_GAP : IDLE;
      IDLE:     state_n = !axiiv ? IDLE : udp_start ? HEADER : WAIT_GAP;
      HEADER:   state_n = !axiiv ? DRAIN : !hdr_last ? HEADER : (hdr_len > 16'd8) ? PAYLOAD : DRAIN;
      PAYLOAD:  state_n = (!axiiv || pay_last) ? DRAIN : PAYLOAD;
      DRAIN:    state_n = FINISH;
      default:  state_n = axiiv ? WAIT_GAP : IDLE;
    endcase
  end
  udp_csum_acc u_csum (
    .clk        (clk),
    .rst        (rst),
    .clear      (udp_start),
    .init       (pseudo),
    .byte_in    (cur_byte),
    .byte_valid (byte_done),
    .word_in    ({hdr_sr[7:0], cur_byte}),
    .word_valid (state == HEADER && byte_done && bcnt == 16'd5),
    .sum        (sum)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_GAP;
      cc <= '0;
      sr <= '0;
      hdr_sr <= '0;
      bcnt <= '0;
      csum_field <= '0;
      err <= 1'b0;
      axiov <= 1'b0;
      axiod <= '0;
      axi_last <= 1'b0;
      src_port_out <= '0;
      dst_port_out <= '0;
      length_out <= '0;
      header_valid <= 1'b0;
      done <= 1'b0;
      checksum_ok <= 1'b0;
      length_err <= 1'b0;
    end else begin
      state <= state_n;
      cc <= (byte_done || !acc_en) ? 3'd0 : cc + 3'd1;
      if (acc_en) sr <= cur_byte;
      bcnt <= !acc_en ? 16'd0 : byte_done ? bcnt + 16'd1 : bcnt;
      if (byte_done) hdr_sr <= {hdr_sr[47:0], cur_byte};
      header_valid <= hdr_last;
      if (hdr_last) begin
        src_port_out <= hdr_sr[55:40];
        dst_port_out <= hdr_sr[39:24];
        length_out <= hdr_len;
        csum_field <= {hdr_sr[7:0], cur_byte};
      end
      axiov <= state == PAYLOAD && axiiv;
      if (state == PAYLOAD && axiiv) axiod <= axiid;
      axi_last <= pay_last;
      err <= udp_start ? 1'b0 : (((state == HEADER || state == PAYLOAD) && !axiiv) || (hdr_last && hdr_len < 16'd8)) ? 1'b1 : err;
      done <= state == DRAIN;
      if (udp_start) begin
        checksum_ok <= 1'b0;
        length_err <= 1'b0;
      end else if (state == DRAIN) begin
        length_err <= err;
        checksum_ok <= !err && (sum == 16'hFFFF || csum_field == 16'd0);
      end
    end
  end
endmodule

// File: tb/tb_udp_rx.sv
// tb_udp_rx: randomized scoreboard bench for udp_rx against a byte-level UDP reference model
module tb_udp_rx;
  localparam int N = 2;
  localparam int CPB = 8 / N;
  localparam logic [31:0] IP_S = 32'h0A000001;
  localparam logic [31:0] IP_D = 32'h0A000002;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic axiiv = 1'b0;
  logic [N-1:0] axiid = '0;
  logic [7:0] protocol_in = '0;
  logic [31:0] src_ip_in = '0;
  logic [31:0] dst_ip_in = '0;
  logic axiov, axi_last, header_valid, done, checksum_ok, length_err;
  logic [N-1:0] axiod;
  logic [15:0] src_port_out, dst_port_out, length_out;
  udp_rx #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .axiiv        (axiiv),
    .axiid        (axiid),
    .protocol_in  (protocol_in),
    .src_ip_in    (src_ip_in),
    .dst_ip_in    (dst_ip_in),
    .axiov        (axiov),
    .axiod        (axiod),
    .axi_last     (axi_last),
    .src_port_out (src_port_out),
    .dst_port_out (dst_port_out),
    .length_out   (length_out),
    .header_valid (header_valid),
    .done         (done),
    .checksum_ok  (checksum_ok),
    .length_err   (length_err)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {logic [N-1:0] d; logic last; int cyc;} chunk_t;
  typedef struct {logic [15:0] sp; logic [15:0] dp; logic [15:0] len; int cyc;} hdr_t;
  typedef struct {logic ok; logic ok_x; logic err; int cyc;} done_t;
  chunk_t chunk_q[$];
  hdr_t hdr_q[$];
  done_t done_q[$];
  chunk_t ce;
  hdr_t he;
  done_t de;
  logic [7:0] fr[$];
  logic [7:0] pay[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (axiov) begin
      if (chunk_q.size() == 0) chk("unexpected_axiov", axiov, 0);
      else begin
        ce = chunk_q.pop_front();
        chk("axiod", axiod, ce.d);
        chk("axi_last", axi_last, ce.last);
        chk("axiov_cycle", cyc, ce.cyc);
      end
    end else if (axi_last) chk("axi_last_without_axiov", axi_last, 0);
    if (header_valid) begin
      if (hdr_q.size() == 0) chk("unexpected_header_valid", header_valid, 0);
      else begin
        he = hdr_q.pop_front();
        chk("src_port_out", src_port_out, he.sp);
        chk("dst_port_out", dst_port_out, he.dp);
        chk("length_out", length_out, he.len);
        chk("header_valid_cycle", cyc, he.cyc);
      end
    end
    if (done) begin
      if (done_q.size() == 0) chk("unexpected_done", done, 0);
      else begin
        de = done_q.pop_front();
        chk("length_err", length_err, de.err);
        if (!de.ok_x) chk("checksum_ok", checksum_ok, de.ok);
        chk("done_cycle", cyc, de.cyc);
      end
    end
  end

  function automatic logic [15:0] ref_sum(input logic [31:0] s, input logic [31:0] d, input int len);
    int unsigned acc;
    acc = s[31:16] + s[15:0] + d[31:16] + d[15:0] + 17 + len;
    for (int i = 0; i < len; i += 2) acc += {fr[i], (i + 1 < len) ? fr[i+1] : 8'h00};
    while ((acc >> 16) != 0) acc = (acc & 32'hFFFF) + (acc >> 16);
    return acc[15:0];
  endfunction

  task automatic build(input logic [31:0] s, input logic [31:0] d, input logic [15:0] sp, input logic [15:0] dp,
                       input logic [15:0] len, input int npad, input bit zero_ck);
    logic [15:0] ck;
    fr.delete();
    fr.push_back(sp[15:8]); fr.push_back(sp[7:0]);
    fr.push_back(dp[15:8]); fr.push_back(dp[7:0]);
    fr.push_back(len[15:8]); fr.push_back(len[7:0]);
    fr.push_back(8'h00); fr.push_back(8'h00);
    foreach (pay[i]) fr.push_back(pay[i]);
    for (int i = 0; i < npad; i++) fr.push_back(8'($urandom));
    if (len >= 16'd8 && !zero_ck) begin
      ck = ~ref_sum(s, d, int'(len));
      if (ck == 16'h0000) ck = 16'hFFFF;
      fr[6] = ck[15:8];
      fr[7] = ck[7:0];
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_axiov"}, axiov, 0);
    chk({tag, "_axiod"}, axiod, 0);
    chk({tag, "_axi_last"}, axi_last, 0);
    chk({tag, "_src_port"}, src_port_out, 0);
    chk({tag, "_dst_port"}, dst_port_out, 0);
    chk({tag, "_length"}, length_out, 0);
    chk({tag, "_header_valid"}, header_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_checksum_ok"}, checksum_ok, 0);
    chk({tag, "_length_err"}, length_err, 0);
  endtask

  task automatic send(input logic [7:0] proto, input logic [31:0] s, input logic [31:0] d, input int nsend, input int rst_at);
    int len;
    bit live, ended;
    logic [7:0] b;
    logic [N-1:0] ch;
    chunk_t c;
    hdr_t h;
    done_t r;
    len = int'({fr[4], fr[5]});
    live = proto == 8'd17;
    ended = 0;
    for (int i = 0; i < nsend; i++) begin
      b = fr[i];
      for (int j = 0; j < CPB; j++) begin
        @(negedge clk);
        if (i == rst_at && j == 1) chk_zero("after_reset");
        ch = b[j*N +: N];
        axiiv = 1'b1;
        axiid = ch;
        protocol_in = proto;
        src_ip_in = s;
        dst_ip_in = d;
        rst = i == rst_at && j == 0;
        if (rst) live = 0;
        if (live) begin
          if (i == 7 && j == CPB - 1) begin
            h.sp = {fr[0], fr[1]};
            h.dp = {fr[2], fr[3]};
            h.len = 16'(len);
            h.cyc = cyc + 1;
            hdr_q.push_back(h);
          end
          if (len > 8 && i >= 8 && i < len) begin
            c.d = ch;
            c.last = i == len - 1 && j == CPB - 1;
            c.cyc = cyc + 1;
            chunk_q.push_back(c);
          end
          if (j == CPB - 1 && ((len > 8 && i == len - 1) || (len <= 8 && i == 7))) begin
            ended = 1;
            r.err = len < 8;
            r.ok_x = len < 8;
            r.ok = (len >= 8) ? (ref_sum(s, d, len) == 16'hFFFF || {fr[6], fr[7]} == 16'h0000) : 1'b0;
            r.cyc = cyc + 2;
            done_q.push_back(r);
          end
        end
      end
    end
    @(negedge clk);
    axiiv = 1'b0;
    axiid = '0;
    rst = 1'b0;
    if (live && !ended) begin
      r.err = 1'b1;
      r.ok = 1'b0;
      r.ok_x = 1'b0;
      r.cyc = cyc + 2;
      done_q.push_back(r);
    end
    repeat (6) @(negedge clk);
    chk("pending_chunks", chunk_q.size(), 0);
    chk("pending_headers", hdr_q.size(), 0);
    chk("pending_done", done_q.size(), 0);
  endtask

  task automatic set_pay(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    build(IP_S, IP_D, 16'h1234, 16'h5678, 16'd12, 0, 0);
    send(8'd17, IP_S, IP_D, 12, -1);
    chk("basic_checksum_ok_held", checksum_ok, 1);
    build(IP_S, IP_D, 16'h1234, 16'h5678, 16'd12, 0, 0);
    fr[9] = fr[9] ^ 8'h01;
    send(8'd17, IP_S, IP_D, 12, -1);
    chk("flipped_checksum_ok_held", checksum_ok, 0);
    build(IP_S, IP_D, 16'h1234, 16'h5678, 16'd12, 0, 1);
    send(8'd17, IP_S, IP_D, 12, -1);
    pay = '{8'hA5};
    build(IP_S, IP_D, 16'h1111, 16'h2222, 16'd9, 10, 0);
    send(8'd17, IP_S, IP_D, 19, -1);
    chk("odd_pad_checksum_ok_held", checksum_ok, 1);
    set_pay(4);
    build(IP_S, IP_D, 16'h0101, 16'h0202, 16'd12, 0, 0);
    send(8'd6, IP_S, IP_D, 12, -1);
    build(IP_S, IP_D, 16'h0303, 16'h0404, 16'd12, 0, 0);
    send(8'd17, IP_S, IP_D, 12, -1);
    set_pay(12);
    build(IP_S, IP_D, 16'hAAAA, 16'hBBBB, 16'd20, 0, 0);
    send(8'd17, IP_S, IP_D, 10, -1);
    chk("truncated_length_err_held", length_err, 1);
    pay.delete();
    build(IP_S, IP_D, 16'hCCCC, 16'hDDDD, 16'd4, 4, 0);
    send(8'd17, IP_S, IP_D, 12, -1);
    set_pay(12);
    build(IP_S, IP_D, 16'h4242, 16'h4343, 16'd20, 4, 0);
    send(8'd17, IP_S, IP_D, 24, 10);
    build(IP_S, IP_D, 16'h5151, 16'h5252, 16'd20, 0, 0);
    send(8'd17, IP_S, IP_D, 20, -1);
    for (int k = 0; k < 40; k++) begin
      int plen, npad, nsend;
      logic [31:0] s, d;
      logic [7:0] proto;
      s = $urandom;
      d = $urandom;
      plen = $urandom_range(0, 30);
      npad = $urandom_range(0, 6);
      proto = ($urandom_range(0, 7) == 0) ? 8'd6 : 8'd17;
      set_pay(plen);
      build(s, d, 16'($urandom), 16'($urandom), 16'(plen + 8), npad, $urandom_range(0, 7) == 0);
      if (plen > 0 && $urandom_range(0, 5) == 0) fr[8 + $urandom_range(0, plen - 1)] ^= 8'h10;
      nsend = ($urandom_range(0, 5) == 0) ? $urandom_range(1, plen + 8 + npad) : plen + 8 + npad;
      send(proto, s, d, nsend, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
